rr_sel6: RTL and testbench

Round-robin select generator for the 6:1 data mux. It arbitrates six request lines and drives the mux's 3-bit select with the winning channel index. It also provides a one-hot grant and a valid flag, so the mux output is sampled only while a channel is held. It sits directly upstream of the 6:1 mux: `sel` connects to the mux select and `req[i]` belongs to mux input `din[i]`.

---
 rtl/rr_sel6.sv | 95 +++++++++
 tb/tb_rr_sel6.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rr_sel6.sv
// Round-robin select generator for a 6:1 mux: registered select, one-hot grant and valid.
// A grant is held until done or HOLD_MAX valid cycles, then the pointer moves past the winner.
module rr_sel6 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [5:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state, state_nx;
    logic [2:0]  ptr, ptr_nx, sel_nx, pick, ofs;
    logic [5:0]  gnt_nx, rot;
    logic [11:0] dbl;
    logic [3:0]  sum;
    logic [7:0]  cnt, cnt_nx;
    logic        vld_nx, to_nx, rel;

    // Rotate requests so ptr sits at bit 0; the lowest set bit is the winner's offset.
    always_comb begin
        dbl = {req, req};
        rot = 6'(dbl >> ptr);
        ofs = 3'd0;
        for (int k = 5; k >= 0; k--)
            if (rot[k]) ofs = 3'(k);
        sum  = {1'b0, ptr} + {1'b0, ofs};
        pick = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        gnt_nx   = gnt;
        vld_nx   = gnt_valid;
        to_nx    = 1'b0;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        rel      = 1'b0;
        case (state)
            IDLE: begin
                gnt_nx = '0;
                vld_nx = 1'b0;
                if (|req) begin
                    sel_nx   = pick;
                    gnt_nx   = 6'b000001 << pick;
                    vld_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // done wins over the hold limit, so a coincident limit is not a timeout
                if (done || cnt == 8'(HOLD_MAX - 1)) begin
                    rel   = 1'b1;
                    to_nx = ~done;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
                if (rel) begin
                    state_nx = IDLE;
                    vld_nx   = 1'b0;
                    gnt_nx   = '0;
                    ptr_nx   = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            gnt       <= gnt_nx;
            gnt_valid <= vld_nx;
            timeout   <= to_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_rr_sel6.sv
// Directed + random bench for rr_sel6 against a cycle-level behavioural model of the arbiter.
module tb_rr_sel6;
    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] req = 6'b111111;
    logic       done = 1'b0;
    logic [2:0] sel;
    logic [5:0] gnt;
    logic       gnt_valid, timeout;

    int ncmp = 0;
    int nbad = 0;

    // reference model: who owns the mux, how many valid cycles it has had, where priority starts
    bit m_busy = 0;
    int m_sel = 0, m_ptr = 0, m_held = 0;
    bit m_to = 0;

    rr_sel6 #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (m_busy) begin
            m_to = 0;
            if (done) begin
                m_busy = 0; m_ptr = (m_sel + 1) % 6;
            end else if (m_held == HM) begin
                m_busy = 0; m_ptr = (m_sel + 1) % 6; m_to = 1;
            end else begin
                m_held++;
            end
        end else begin
            m_to = 0;
            if (req != 0) begin
                for (int k = 0; k < 6; k++)
                    if (!m_busy && req[(m_ptr + k) % 6]) begin
                        m_sel = (m_ptr + k) % 6; m_busy = 1; m_held = 1;
                    end
            end
        end
    endtask

    task automatic step();
        logic [5:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = m_busy ? (6'b000001 << m_sel) : 6'b0;
        chk("sel", {5'b0, sel}, 8'(m_sel));
        chk("gnt", {2'b0, gnt}, {2'b0, eg});
        chk("gnt_valid", {7'b0, gnt_valid}, {7'b0, m_busy});
        chk("timeout", {7'b0, timeout}, {7'b0, m_to});
    endtask

    initial begin
        // reset held with all channels requesting
        rst = 1; req = 6'b111111; done = 0;
        step(); step();
        rst = 0;
        // rotation 0..5,0 with done on the first valid cycle
        for (int g = 0; g < 7; g++) begin
            done = 0; step();
            chk("rot_sel", {5'b0, sel}, 8'(g % 6));
            done = 1; step();
        end
        done = 0;
        // skip and wrap past empty channel 5
        req = 6'b010000; step();
        chk("grant4", {5'b0, sel}, 8'd4);
        done = 1; step(); done = 0;
        req = 6'b001001; step();
        chk("wrap_sel0", {5'b0, sel}, 8'd0);
        done = 1; step(); done = 0; step();
        chk("next_sel3", {5'b0, sel}, 8'd3);
        done = 1; step(); done = 0;
        // forced release after HM cycles
        req = 6'b000100; step();
        for (int i = 0; i < HM - 1; i++) step();
        chk("held_valid", {7'b0, gnt_valid}, 8'd1);
        step();
        chk("timeout_pulse", {7'b0, timeout}, 8'd1);
        step();
        chk("regrant2", {5'b0, sel}, 8'd2);
        // drop req mid-grant, done coincides with the limit
        req = 6'b0; step(); step(); step();
        chk("drop_held", {7'b0, gnt_valid}, 8'd1);
        done = 1; step(); done = 0;
        chk("done_at_limit_to", {7'b0, timeout}, 8'd0);
        // reset on second valid cycle of a grant to channel 3
        req = 6'b001000; step(); step();
        chk("mid_sel3", {5'b0, sel}, 8'd3);
        rst = 1; req = 6'b111111; step();
        rst = 0; step();
        chk("post_rst_sel0", {5'b0, sel}, 8'd0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            req  = 6'($urandom);
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 0; done = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
